// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: full-duplex UART with configurable data width, parity and stop bits.
// Ports: clk, rst (sync, active-high); tx_data/tx_valid/tx_ready handshake and tx serial out;
// rx serial in (async), rx_data with rx_valid pulse, rx_parity_err and rx_frame_err status.
module uart_frame_ctrl #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int DATA_WIDTH       = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic HAS_PARITY = (PARITY != 0);
    localparam logic ODD        = (PARITY == 2);

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PARITY, T_STOP
    } tx_state_t;

    tx_state_t             tx_state;
    logic [CW-1:0]         tx_cnt;
    logic [3:0]            tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par;
    logic                  tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            unique case (tx_state)
                T_IDLE: begin
                    tx_cnt <= '0;
                    // tx_ready is always high here, so tx_valid alone accepts
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ ODD;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_state <= T_START;
                    end
                end
                T_START: begin
                    if (tx_tick) begin
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_state <= T_DATA;
                    end
                end
                T_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == DATA_LAST) begin
                            tx_bit <= '0;
                            if (HAS_PARITY) begin
                                tx       <= tx_par;
                                tx_state <= T_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= T_STOP;
                            end
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                T_PARITY: begin
                    if (tx_tick) begin
                        tx       <= 1'b1;
                        tx_state <= T_STOP;
                    end
                end
                T_STOP: begin
                    if (tx_tick) begin
                        if (tx_bit == STOP_LAST) begin
                            tx_ready <= 1'b1;
                            tx_state <= T_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_IDLE
    } rx_state_t;

    rx_state_t             rx_state;
    logic                  rx_meta;
    logic                  rx_sync;
    logic [CW-1:0]         rx_cnt;
    logic [3:0]            rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_par_bad;
    logic                  rx_tick;

    assign rx_tick = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_state      <= R_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bad    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            rx_cnt   <= rx_tick ? '0 : rx_cnt + 1'b1;
            unique case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= R_START;
                end
                R_START: begin
                    // half a bit in: still low means a real start bit,
                    // and every later sample lands mid-bit
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_state <= HAS_PARITY ? R_PARITY : R_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                R_PARITY: begin
                    if (rx_tick) begin
                        rx_par_bad <= rx_sync ^ (^rx_shift) ^ ODD;
                        rx_state   <= R_STOP;
                    end
                end
                R_STOP: begin
                    if (rx_tick) begin
                        rx_data       <= rx_shift;
                        rx_valid      <= 1'b1;
                        rx_parity_err <= HAS_PARITY && rx_par_bad;
                        rx_frame_err  <= !rx_sync;
                        // a low stop bit may be a break: wait for the line to recover
                        rx_state      <= rx_sync ? R_IDLE : R_WAIT_IDLE;
                    end
                end
                R_WAIT_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_sync) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule
